regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port (regwrite/wra/wd) among NREQ writeback sources, e.g. ALU writeback, load writeback and link-register write.
- Uses round-robin arbitration with a req/gnt handshake.
- Drives the write port from registered outputs; sits between the writeback stages and the register file.

---
 rtl/regfile_wb_if.sv | 26 ++
 rtl/regfile_wb_arbiter.sv | 93 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_if.sv
// Writeback-source-to-register-file write-port bundle: requests, grants and the shared write port.
interface regfile_wb_if #(
    parameter int NREQ = 2,
    parameter int DW   = 32,
    parameter int AW   = 5
);
    logic                 hold;
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      gnt;
    logic                 regwrite;
    logic [AW-1:0]        wra;
    logic [DW-1:0]        wd;
    logic                 conflict;

    modport master (
        output hold, req, req_addr, req_data,
        input  gnt, regwrite, wra, wd, conflict
    );

    modport slave (
        input  hold, req, req_addr, req_data,
        output gnt, regwrite, wra, wd, conflict
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NREQ writeback sources.
// Optional REGFILE_WB_R0_DISCARD_EN: grants to register 0 still pulse gnt but suppress regwrite.
module regfile_wb_arbiter #(
    parameter int NREQ = 2,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic         clk,
    input  logic         rst,
    regfile_wb_if.slave  wb
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr_reg, ptr_next;
    logic [NREQ-1:0] gnt_reg, gnt_next;
    logic            regwrite_reg, regwrite_next;
    logic [AW-1:0]   wra_reg, wra_next;
    logic [DW-1:0]   wd_reg, wd_next;
    logic            conflict_reg, conflict_next;

    logic [NREQ-1:0] elig;
    logic [PW-1:0]   win;
    logic            found;

    // The previous grant masks its own requester so a stale req is never granted twice.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_elig
            assign elig[gi] = wb.req[gi] & ~gnt_reg[gi];
        end
    endgenerate

    // Scan downward so the eligible index closest to ptr is the last one written.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr_reg) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (elig[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    always_comb begin
        gnt_next      = '0;
        regwrite_next = 1'b0;
        conflict_next = 1'b0;
        wra_next      = wra_reg;
        wd_next       = wd_reg;
        ptr_next      = ptr_reg;
        if (!wb.hold && found) begin
            gnt_next[win] = 1'b1;
            wra_next      = wb.req_addr[int'(win)*AW +: AW];
            wd_next       = wb.req_data[int'(win)*DW +: DW];
`ifdef REGFILE_WB_R0_DISCARD_EN
            regwrite_next = (wb.req_addr[int'(win)*AW +: AW] != '0);
`else
            regwrite_next = 1'b1;
`endif
            ptr_next      = (int'(win) == NREQ - 1) ? '0 : PW'(int'(win) + 1);
            conflict_next = ($countones(elig) > 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg      <= '0;
            gnt_reg      <= '0;
            regwrite_reg <= 1'b0;
            wra_reg      <= '0;
            wd_reg       <= '0;
            conflict_reg <= 1'b0;
        end else begin
            ptr_reg      <= ptr_next;
            gnt_reg      <= gnt_next;
            regwrite_reg <= regwrite_next;
            wra_reg      <= wra_next;
            wd_reg       <= wd_next;
            conflict_reg <= conflict_next;
        end
    end

    assign wb.gnt      = gnt_reg;
    assign wb.regwrite = regwrite_reg;
    assign wb.wra      = wra_reg;
    assign wb.wd       = wd_reg;
    assign wb.conflict = conflict_reg;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios then randomized traffic against a reference model.
module tb_regfile_wb_arbiter;
    localparam int NREQ = 2;
    localparam int DW   = 32;
    localparam int AW   = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

    regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int              m_ptr;
    logic [NREQ-1:0] m_last;
    logic [NREQ-1:0] exp_gnt;
    logic            exp_rw;
    logic [AW-1:0]   exp_wra;
    logic [DW-1:0]   exp_wd;
    logic            exp_conf;

    logic [AW-1:0]   addr [NREQ];
    logic [DW-1:0]   data [NREQ];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_bus();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i*AW +: AW] = addr[i];
            bus.req_data[i*DW +: DW] = data[i];
        end
    endtask

    // What the arbiter must present after the coming edge, from the rules in plain terms.
    task automatic model_edge();
        int n_elig;
        int w;
        n_elig = 0;
        w = -1;
        if (rst) begin
            m_ptr = 0; m_last = '0; exp_gnt = '0; exp_rw = 0;
            exp_wra = '0; exp_wd = '0; exp_conf = 0;
            return;
        end
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (bus.req[i] && !m_last[i]) begin
                n_elig++;
                if (w < 0) w = i;
            end
        end
        exp_gnt = '0; exp_rw = 0; exp_conf = 0;
        if (!bus.hold && w >= 0) begin
            exp_gnt[w] = 1'b1;
            exp_wra = addr[w];
            exp_wd  = data[w];
`ifdef REGFILE_WB_R0_DISCARD_EN
            exp_rw = (addr[w] != 0);
`else
            exp_rw = 1'b1;
`endif
            exp_conf = (n_elig > 1);
            m_ptr = (w + 1) % NREQ;
        end
        m_last = exp_gnt;
    endtask

    task automatic step();
        drive_bus();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check("gnt", 64'(bus.gnt), 64'(exp_gnt));
        check("regwrite", 64'(bus.regwrite), 64'(exp_rw));
        check("wra", 64'(bus.wra), 64'(exp_wra));
        check("wd", 64'(bus.wd), 64'(exp_wd));
        check("conflict", 64'(bus.conflict), 64'(exp_conf));
        $display("cyc rst=%0b hold=%0b req=%b gnt=%b rw=%0b wra=%0d wd=%08h conf=%0b",
                 rst, bus.hold, bus.req, bus.gnt, bus.regwrite, bus.wra, bus.wd, bus.conflict);
    endtask

    logic [NREQ-1:0] prev_gnt;

    initial begin
        rst = 1'b1; bus.hold = 1'b0; bus.req = '0;
        for (int i = 0; i < NREQ; i++) begin addr[i] = AW'(i + 1); data[i] = DW'(32'h100 + i); end
        @(negedge clk);

        // Reset held with both requesting
        bus.req = 2'b11;
        step(); check("rst_gnt0", 64'(bus.gnt), 0); check("rst_rw0", 64'(bus.regwrite), 0);
        step(); check("rst_gnt1", 64'(bus.gnt), 0);
        rst = 1'b0;
        step(); check("first_gnt_r0", 64'(bus.gnt), 64'h1);
        bus.req = '0;
        step(); step();

        // Single requester
        addr[1] = 5'd7; data[1] = 32'hDEADBEEF; bus.req = 2'b10;
        step();
        check("single_gnt", 64'(bus.gnt), 64'h2);
        check("single_wra", 64'(bus.wra), 64'd7);
        check("single_wd", 64'(bus.wd), 64'hDEADBEEF);
        step(); check("single_gap", 64'(bus.gnt), 0);
        step(); check("single_regnt", 64'(bus.gnt), 64'h2);
        bus.req = '0;
        step(); step();

        // Contention: grants alternate and never repeat back-to-back
        bus.req = 2'b11; prev_gnt = '0;
        for (int c = 0; c < 6; c++) begin
            step();
            check("no_consec", 64'(bus.gnt & prev_gnt), 0);
            prev_gnt = bus.gnt;
        end
        bus.req = '0;
        step(); step();

        // hold
        addr[0] = 5'd9; data[0] = 32'hCAFE0001; bus.req = 2'b01; bus.hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(); check("hold_gnt", 64'(bus.gnt), 0); check("hold_rw", 64'(bus.regwrite), 0);
        end
        bus.hold = 1'b0;
        step();
        check("unhold_gnt", 64'(bus.gnt), 64'h1);
        check("unhold_wra", 64'(bus.wra), 64'd9);
        check("unhold_wd", 64'(bus.wd), 64'hCAFE0001);
        bus.req = '0;
        step();

        // Reset mid-stream with req[1] pending
        addr[1] = 5'd21; data[1] = 32'h0BADF00D; bus.req = 2'b01;
        step();
        bus.req = 2'b10; rst = 1'b1;
        step();
        check("midrst_gnt", 64'(bus.gnt), 0);
        check("midrst_wd", 64'(bus.wd), 0);
        rst = 1'b0;
        step();
        check("midrst_regnt", 64'(bus.gnt), 64'h2);
        check("midrst_wra", 64'(bus.wra), 64'd21);
        check("midrst_wd2", 64'(bus.wd), 64'h0BADF00D);
        bus.req = '0;
        step(); step();

        // Write to register 0
        addr[0] = '0; data[0] = 32'h1234; bus.req = 2'b01;
        step();
        check("r0_gnt", 64'(bus.gnt), 64'h1);
`ifdef REGFILE_WB_R0_DISCARD_EN
        check("r0_rw", 64'(bus.regwrite), 0);
`else
        check("r0_rw", 64'(bus.regwrite), 64'h1);
`endif
        check("r0_wd", 64'(bus.wd), 64'h1234);
        bus.req = '0;
        step();

        // Randomized traffic obeying the req/gnt handshake
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req[i] && exp_gnt[i]) begin
                    if ($urandom_range(1, 0) == 1) bus.req[i] = 1'b0;
                    else begin
                        addr[i] = AW'($urandom_range(31, 0));
                        data[i] = DW'($urandom);
                    end
                end else if (!bus.req[i] && $urandom_range(9, 0) < 5) begin
                    bus.req[i] = 1'b1;
                    addr[i] = AW'($urandom_range(31, 0));
                    data[i] = DW'($urandom);
                end
            end
            bus.hold = ($urandom_range(9, 0) == 0);
            rst = ($urandom_range(39, 0) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
